// File: rtl/usb_rx_sie.sv
// Low-speed USB receive SIE front end: NRZI decode, SYNC hunt, bit unstuffing,
// LSB-first byte assembly and EOP detection. Optional bus-reset detect: USB_RX_BUS_RESET_EN.
package types;
  typedef enum logic [1:0] {D_SE0 = 2'b00, D_J = 2'b01, D_K = 2'b10, D_SE1 = 2'b11} d_port_t;
endpackage

module usb_rx_sie #(
  parameter int SYNC_ZEROS       = 5,
  parameter int BUS_RESET_CYCLES = 60
) (
  input  logic            clk,
  input  logic            reset,
  input  types::d_port_t  d,
  input  logic            strobe,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            rx_active,
  output logic            rx_error,
  output logic            eop,
  output logic            bus_reset
);
  import types::*;

  if (SYNC_ZEROS < 1 || SYNC_ZEROS > 7 || BUS_RESET_CYCLES < 1) begin : g_bad_param
    $error("usb_rx_sie: parameter out of range");
  end

  localparam logic [2:0] ZMIN = 3'(SYNC_ZEROS);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_DATA, S_EOP, S_ERR} state_t;

  state_t     r_state, w_state_nx;
  d_port_t    r_prev;
  logic [2:0] r_zero_cnt, w_zero_nx;
  logic [2:0] r_bit_cnt, w_bit_nx;
  logic [2:0] r_ones_cnt, w_ones_nx;
  logic [6:0] r_shift;
  logic       w_jk, w_bit, w_take, w_err, w_eop, w_act_nx, w_force;

  assign w_jk  = (d == D_J) || (d == D_K);
  assign w_bit = (d == r_prev);

`ifdef USB_RX_BUS_RESET_EN
  localparam logic [15:0] BR_LAST = 16'(BUS_RESET_CYCLES - 1);
  logic [15:0] r_br_cnt;

  // Runs every clk, independent of strobe; saturates so a long SE0 cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_cnt  <= 16'd0;
      bus_reset <= 1'b0;
    end else if (d == D_SE0) begin
      if (r_br_cnt != 16'hFFFF) r_br_cnt <= r_br_cnt + 16'd1;
      if (r_br_cnt >= BR_LAST) bus_reset <= 1'b1;
    end else begin
      r_br_cnt  <= 16'd0;
      bus_reset <= 1'b0;
    end
  end
  assign w_force = bus_reset;
`else
  assign bus_reset = 1'b0;
  assign w_force   = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_zero_nx  = r_zero_cnt;
    w_bit_nx   = r_bit_cnt;
    w_ones_nx  = r_ones_cnt;
    w_take     = 1'b0;
    w_err      = 1'b0;
    w_eop      = 1'b0;
    w_act_nx   = rx_active;
    if (strobe) begin
      unique case (r_state)
        S_IDLE: if (d == D_K) begin
          w_state_nx = S_HUNT;
          w_zero_nx  = 3'd1;
        end
        S_HUNT: begin
          if (!w_jk) w_state_nx = S_IDLE;
          else if (!w_bit) begin
            if (r_zero_cnt != 3'd7) w_zero_nx = r_zero_cnt + 3'd1;
          end else if (r_zero_cnt >= ZMIN) begin
            w_state_nx = S_DATA;
            w_act_nx   = 1'b1;
            w_bit_nx   = 3'd0;
            w_ones_nx  = 3'd0;
          end else w_state_nx = S_IDLE;
        end
        S_DATA: begin
          if (w_jk) begin
            if (r_ones_cnt == 3'd6) begin
              if (!w_bit) w_ones_nx = 3'd0;
              else begin
                w_err      = 1'b1;
                w_act_nx   = 1'b0;
                w_state_nx = S_ERR;
              end
            end else begin
              w_take    = 1'b1;
              w_bit_nx  = r_bit_cnt + 3'd1;
              w_ones_nx = w_bit ? r_ones_cnt + 3'd1 : 3'd0;
            end
          end else if (d == D_SE0) begin
            // SE0 mid-byte still leads to EOP, but the packet is flagged bad.
            w_err      = (r_bit_cnt != 3'd0);
            w_state_nx = S_EOP;
          end else begin
            w_err      = 1'b1;
            w_act_nx   = 1'b0;
            w_state_nx = S_ERR;
          end
        end
        S_EOP: begin
          if (d == D_J) begin
            w_eop      = 1'b1;
            w_act_nx   = 1'b0;
            w_state_nx = S_IDLE;
          end else if (d != D_SE0) begin
            w_err      = 1'b1;
            w_act_nx   = 1'b0;
            w_state_nx = S_ERR;
          end
        end
        S_ERR: if (d == D_J) w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
    if (w_force) begin
      w_state_nx = S_IDLE;
      w_act_nx   = 1'b0;
      w_err      = 1'b0;
      w_eop      = 1'b0;
      w_take     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_prev     <= D_J;
      r_zero_cnt <= 3'd0;
      r_bit_cnt  <= 3'd0;
      r_ones_cnt <= 3'd0;
      r_shift    <= 7'd0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_active  <= 1'b0;
      rx_error   <= 1'b0;
      eop        <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_zero_cnt <= w_zero_nx;
      r_bit_cnt  <= w_bit_nx;
      r_ones_cnt <= w_ones_nx;
      rx_active  <= w_act_nx;
      rx_error   <= w_err;
      eop        <= w_eop;
      rx_valid   <= w_take && (r_bit_cnt == 3'd7);
      if (strobe && w_jk) r_prev <= d;
      if (w_take) begin
        if (r_bit_cnt == 3'd7) rx_data <= {w_bit, r_shift};
        else r_shift[r_bit_cnt] <= w_bit;
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_sie.sv
// Directed bench for usb_rx_sie: line-symbol strings are NRZI-encoded here and
// played at one strobe per 16 clk; pulses are tallied on the falling edge.
module tb_usb_rx_sie;
  import types::*;

`ifdef USB_RX_BUS_RESET_EN
  localparam int BR = 1;
`else
  localparam int BR = 0;
`endif

  logic       clk = 1'b0, reset = 1'b1, strobe = 1'b0;
  d_port_t    d = D_J;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error, eop, bus_reset;

  usb_rx_sie dut (
    .clk(clk), .reset(reset), .d(d), .strobe(strobe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_error(rx_error), .eop(eop), .bus_reset(bus_reset)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_eop = 0, n_err = 0, n_act = 0, n_clash = 0;
  logic [7:0] got[$];

  always @(negedge clk) if (!reset) begin
    if (rx_valid) got.push_back(rx_data);
    if (eop) n_eop++;
    if (rx_error) n_err++;
    if (rx_active) n_act++;
    if (rx_valid && eop) n_clash++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send(input d_port_t s);
    d = s; strobe = 1'b1; tick; strobe = 1'b0;
    repeat (15) tick;
  endtask

  // '0'/'1' = decoded bits (NRZI from current level), J/K = literal, S = SE0, E = SE1
  d_port_t lvl = D_J;
  task automatic play(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "0": begin lvl = (lvl == D_J) ? D_K : D_J; send(lvl); end
        "1": send(lvl);
        "J": begin lvl = D_J; send(lvl); end
        "K": begin lvl = D_K; send(lvl); end
        "S": send(D_SE0);
        "E": send(D_SE1);
        default: ;
      endcase
    end
  endtask

  typedef struct {
    string      name;
    string      sym;
    int         nv;
    logic [7:0] b0, b1;
    int         ne, nr;
  } vec_t;

  function automatic vec_t mk(input string n, input string s, input int nv,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input int ne, input int nr);
    vec_t v;
    v.name = n; v.sym = s; v.nv = nv; v.b0 = b0; v.b1 = b1; v.ne = ne; v.nr = nr;
    return v;
  endfunction

  vec_t tbl[$];
  string SYNC = "KJKJKJKK";

  initial begin
    int v0, e0, r0, a0;
    tbl.push_back(mk("a5",       {SYNC, "10100101", "SSJ"},              1, 8'hA5, 8'h00, 1, 0));
    tbl.push_back(mk("ff_stuff", {SYNC, "111111011", "00000000", "SSJ"}, 2, 8'hFF, 8'h00, 1, 0));
    tbl.push_back(mk("stufferr", {SYNC, "1111111", "J", SYNC, "00111100", "SSJ"}, 1, 8'h3C, 8'h00, 1, 1));
    tbl.push_back(mk("partial",  {SYNC, "101", "SSJ"},                   0, 8'h00, 8'h00, 1, 1));
    tbl.push_back(mk("se1_data", {SYNC, "10", "E", "J"},                 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk("eop_k",    {SYNC, "00000000", "S", "K", "J"},      1, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk("two_byte", {SYNC, "01111000", "11000011", "SSSJ"}, 2, 8'h1E, 8'hC3, 1, 0));

    repeat (3) tick;
    chk("rst rx_data",   rx_data,   8'h00);
    chk("rst rx_valid",  rx_valid,  0);
    chk("rst rx_active", rx_active, 0);
    chk("rst rx_error",  rx_error,  0);
    chk("rst eop",       eop,       0);
    chk("rst bus_reset", bus_reset, 0);
    reset = 1'b0;
    play("JJ");

    // truncated SYNC must not start a packet
    v0 = got.size(); e0 = n_eop; r0 = n_err; a0 = n_act;
    play("KJKK");
    chk("trunc active", n_act - a0, 0);
    chk("trunc valid",  got.size() - v0, 0);
    chk("trunc err",    n_err - r0, 0);
    play({SYNC, "00111100", "SSJ", "JJ"});
    chk("trunc next valid", got.size() - v0, 1);
    if (got.size() > v0) chk("trunc next byte", got[v0], 8'h3C);
    chk("trunc next eop", n_eop - e0, 1);

    foreach (tbl[i]) begin
      v0 = got.size(); e0 = n_eop; r0 = n_err; a0 = n_act;
      play(tbl[i].sym);
      play("JJ");
      chk({tbl[i].name, " nvalid"}, got.size() - v0, tbl[i].nv);
      if (got.size() - v0 >= 1) chk({tbl[i].name, " byte0"}, got[v0], tbl[i].b0);
      if (got.size() - v0 >= 2) chk({tbl[i].name, " byte1"}, got[v0+1], tbl[i].b1);
      chk({tbl[i].name, " eop"},   n_eop - e0, tbl[i].ne);
      chk({tbl[i].name, " err"},   n_err - r0, tbl[i].nr);
      chk({tbl[i].name, " saw_active"}, int'(n_act > a0), 1);
      chk({tbl[i].name, " end_active"}, rx_active, 0);
    end

    // reset mid-packet: outputs clear, no eop/error afterwards
    play({SYNC, "1010"});
    chk("midrst active before", rx_active, 1);
    e0 = n_eop; r0 = n_err;
    reset = 1'b1; tick;
    chk("midrst active", rx_active, 0);
    chk("midrst data",   rx_data, 8'h00);
    chk("midrst error",  rx_error, 0);
    reset = 1'b0; lvl = D_J;
    play("JJJ");
    chk("midrst eop",  n_eop - e0, 0);
    chk("midrst err",  n_err - r0, 0);

    // long SE0 after a full byte
    v0 = got.size();
    play({SYNC, "00000000"});
    chk("br byte", got.size() - v0, 1);
    e0 = n_eop; r0 = n_err;
    d = D_SE0;
    for (int k = 1; k <= 70; k++) begin
      strobe = ((k - 1) % 16 == 0);
      tick;
      if (k == 59) chk("br clk59", bus_reset, 0);
      if (k == 60) chk("br clk60", bus_reset, BR);
      if (k == 70) begin
        chk("br clk70", bus_reset, BR);
        chk("br active", rx_active, 1 - BR);
      end
    end
    d = D_J; lvl = D_J; strobe = 1'b1; tick; strobe = 1'b0;
    chk("br after J", bus_reset, 0);
    repeat (15) tick;
    chk("br eop",       n_eop - e0, 1 - BR);
    chk("br err",       n_err - r0, 0);
    chk("br end active", rx_active, 0);

    // normal packet still received afterwards
    v0 = got.size();
    play({SYNC, "10100101", "SSJ", "JJ"});
    chk("post valid", got.size() - v0, 1);
    if (got.size() > v0) chk("post byte", got[v0], 8'hA5);

    chk("valid/eop overlap", n_clash, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
